reglist_encoder: RTL

// - Sequential priority encoder for LDM/STM register lists: captures a one-hot-per-register list,

---
 rtl/reglist_encoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/reglist_encoder.sv
// reglist_encoder: sequential priority encoder for LDM/STM register lists.
// Captures a register list on start, then emits one register index per
// idx_valid/idx_ready handshake, lowest set bit first. Defining the macro
// REGLIST_DESCEND_EN reverses the order so the highest set bit comes first.
module reglist_encoder #(
  parameter int N = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N-1:0]           list,
  output logic                   busy,
  output logic                   idx_valid,
  input  logic                   idx_ready,
  output logic [$clog2(N)-1:0]   idx,
  output logic                   last,
  output logic [$clog2(N):0]     count,
  output logic                   done
);

  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_next;
  logic [N-1:0]   mask, mask_next;
  logic [W:0]     count_next;
  logic           done_next;
  logic [W-1:0]   sel_idx;
  logic [N-1:0]   sel_bit;
  logic           single;
  logic           run;

  function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) r = W'(i);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] highest_idx(input logic [N-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) r = W'(i);
    end
    return r;
  endfunction

  function automatic logic [W:0] popcount(input logic [N-1:0] m);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{W{1'b0}}, m[i]};
    end
    return c;
  endfunction

  // Pick the index to emit from the remaining mask; order is build-selected.
  always_comb begin
`ifdef REGLIST_DESCEND_EN
    sel_idx = highest_idx(mask);
`else
    sel_idx = lowest_idx(mask);
`endif
    sel_bit = {{(N-1){1'b0}}, 1'b1} << sel_idx;
    single  = (mask != '0) && ((mask & (mask - 1'b1)) == '0);
  end

  assign run       = (state == RUN);
  assign busy      = run;
  assign idx_valid = run;
  assign idx       = run ? sel_idx : '0;
  assign last      = run & single;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, mask update, count capture and done generation.
  always_comb begin
    state_next = state;
    mask_next  = mask;
    count_next = count;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mask_next  = list;
          count_next = popcount(list);
          if (list != '0) state_next = RUN;
          else            done_next  = 1'b1;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: list and count stay put.
        if (idx_ready) begin
          mask_next = mask & ~sel_bit;
          if (single) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: remaining mask, captured popcount and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask  <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      mask  <= mask_next;
      count <= count_next;
      done  <= done_next;
    end
  end

endmodule
